// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone arbiter sharing one PSRAM controller port.
// Holds the grant for a whole transaction; round-robin or m0-priority with starvation guard.
module psram_wb_arbiter #(
    parameter int unsigned PRIO_MODE  = 0,
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(MAX_CONSEC);

    logic [0:0]       state;
    logic [1:0]       gnt;
    logic             last_m1;
    logic [CNT_W-1:0] consec;

    logic req0, req1;
    logic pick_m1;
    logic gnt_cyc;
    logic gnt_stb;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_comb begin
        pick_m1 = 1'b0;
        if (req1 && !req0) begin
            pick_m1 = 1'b1;
        end else if (req0 && req1) begin
            if (PRIO_MODE == 0)
                pick_m1 = ~last_m1;
            else
                pick_m1 = (consec == CONSEC_MAX);
        end
    end

    always_comb begin
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        if (gnt[0]) begin
            gnt_cyc = m0_cyc_i;
            gnt_stb = m0_stb_i;
        end else if (gnt[1]) begin
            gnt_cyc = m1_cyc_i;
            gnt_stb = m1_stb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            last_m1 <= 1'b1;
            consec  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state   <= ST_GRANT;
                        gnt     <= pick_m1 ? 2'b10 : 2'b01;
                        last_m1 <= pick_m1;
                        // consec only counts m0 grants that made a waiting m1 wait longer
                        if (pick_m1 || !req1)
                            consec <= '0;
                        else if (consec != CONSEC_MAX)
                            consec <= consec + 1'b1;
                    end
                end
                ST_GRANT: begin
                    // ack ends the transaction; a dropped cyc aborts it without retry
                    if (s_ack_i || !gnt_cyc) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        if (gnt[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
        end else if (gnt[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
        end
    end

    assign s_cyc_o  = (state == ST_GRANT) & gnt_cyc & gnt_stb;
    assign s_stb_o  = (state == ST_GRANT) & gnt_cyc & gnt_stb;

    assign m0_ack_o = s_ack_i & gnt[0] & req0;
    assign m1_ack_o = s_ack_i & gnt[1] & req1;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt;

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Directed self-checking bench for psram_wb_arbiter: a round-robin instance (a)
// and an m0-priority instance (b) share master inputs but have separate slave acks.
module tb_psram_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [31:0] sdat;
    logic        ack_a, ack_b;

    logic [31:0] a_m0_dat, a_m1_dat, a_adr, a_dat;
    logic [3:0]  a_sel;
    logic        a_m0_ack, a_m1_ack, a_we, a_cyc, a_stb;
    logic [1:0]  a_gnt;

    logic [31:0] b_m0_dat, b_m1_dat, b_adr, b_dat;
    logic [3:0]  b_sel;
    logic        b_m0_ack, b_m1_ack, b_we, b_cyc, b_stb;
    logic [1:0]  b_gnt;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    psram_wb_arbiter #(.PRIO_MODE(0), .MAX_CONSEC(4), .CNT_W(3)) u_rr (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(a_m0_ack),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(a_m1_ack),
        .s_adr_o(a_adr), .s_dat_o(a_dat), .s_sel_o(a_sel), .s_we_o(a_we),
        .s_cyc_o(a_cyc), .s_stb_o(a_stb), .s_dat_i(sdat), .s_ack_i(ack_a),
        .gnt_o(a_gnt)
    );

    psram_wb_arbiter #(.PRIO_MODE(1), .MAX_CONSEC(4), .CNT_W(3)) u_prio (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(b_m0_ack),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(b_m1_ack),
        .s_adr_o(b_adr), .s_dat_o(b_dat), .s_sel_o(b_sel), .s_we_o(b_we),
        .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_dat_i(sdat), .s_ack_i(ack_b),
        .gnt_o(b_gnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_masters();
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    endtask

    // Reset with both masters actively requesting and acks high: every output must stay quiet.
    task automatic do_reset();
        rst_i = 1'b1;
        m0_adr = 32'hDEAD_BEEF; m0_dat = 32'h5555_5555; m0_sel = 4'hF; m0_we = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'hCAFE_F00D; m1_dat = 32'hAAAA_AAAA; m1_sel = 4'hF; m1_we = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        ack_a = 1'b1; ack_b = 1'b1; sdat = '0;
        tick();
        tick();
        chk("rst_a_gnt", 32'(a_gnt), 32'h0);
        chk("rst_a_ctl", 32'({a_cyc, a_stb, a_we, a_sel, a_m1_ack, a_m0_ack}), 32'h0);
        chk("rst_a_adr", a_adr, 32'h0);
        chk("rst_a_dat", a_dat, 32'h0);
        chk("rst_b_gnt", 32'(b_gnt), 32'h0);
        chk("rst_b_ctl", 32'({b_cyc, b_stb, b_we, b_sel, b_m1_ack, b_m0_ack}), 32'h0);
        clear_masters();
        ack_a = 1'b0; ack_b = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    // Wait (bounded) for a grant, check it, ack it, then check the idle bubble that follows.
    task automatic serve(input bit use_b, input logic [1:0] exp, input string tag);
        logic [1:0] g;
        int n;
        n = 0;
        g = use_b ? b_gnt : a_gnt;
        while (g == 2'b00 && n < 4) begin
            tick();
            n++;
            g = use_b ? b_gnt : a_gnt;
        end
        chk({tag, "_gnt"}, 32'(g), 32'(exp));
        chk({tag, "_stb"}, 32'(use_b ? b_stb : a_stb), 32'h1);
        chk({tag, "_adr"}, use_b ? b_adr : a_adr, exp[0] ? m0_adr : m1_adr);
        if (use_b) ack_b = 1'b1; else ack_a = 1'b1;
        #1;
        chk({tag, "_acks"}, 32'(use_b ? {b_m1_ack, b_m0_ack} : {a_m1_ack, a_m0_ack}), 32'(exp));
        tick();
        ack_a = 1'b0; ack_b = 1'b0;
        chk({tag, "_bubble"}, 32'(use_b ? {b_gnt, b_cyc} : {a_gnt, a_cyc}), 32'h0);
    endtask

    initial begin
        rst_i = 1'b0;
        clear_masters();
        ack_a = 1'b0; ack_b = 1'b0; sdat = '0;

        // m0 single read
        do_reset();
        m0_adr = 32'h0000_0010; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        #1;
        chk("t1_latency_gnt", 32'(a_gnt), 32'h0);
        chk("t1_latency_stb", 32'(a_stb), 32'h0);
        tick();
        chk("t1_gnt", 32'(a_gnt), 32'h1);
        chk("t1_adr", a_adr, 32'h0000_0010);
        chk("t1_cycstb", 32'({a_cyc, a_stb}), 32'h3);
        chk("t1_noack", 32'({a_m1_ack, a_m0_ack}), 32'h0);
        sdat = 32'h1234_5678;
        ack_a = 1'b1;
        #1;
        chk("t1_ack", 32'({a_m1_ack, a_m0_ack}), 32'h1);
        chk("t1_rdata", a_m0_dat, 32'h1234_5678);
        tick();
        ack_a = 1'b0;
        clear_masters();
        chk("t1_release", 32'(a_gnt), 32'h0);

        // round-robin alternation
        do_reset();
        m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h0000_0200; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 4; i++)
            serve(1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("t2_%0d", i));
        clear_masters();

        // m0 priority with starvation guard after four consecutive m0 grants
        do_reset();
        m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h0000_0200; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 10; i++)
            serve(1'b1, (i % 5 == 4) ? 2'b10 : 2'b01, $sformatf("t3_%0d", i));
        clear_masters();

        // m1 write held until ack
        do_reset();
        m1_adr = 32'h0000_0200; m1_dat = 32'hAABB_CCDD; m1_sel = 4'b0100; m1_we = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        chk("t4_gnt", 32'(a_gnt), 32'h2);
        chk("t4_we_sel", 32'({a_we, a_sel}), 32'h14);
        chk("t4_dat", a_dat, 32'hAABB_CCDD);
        tick();
        chk("t4_hold_dat", a_dat, 32'hAABB_CCDD);
        chk("t4_hold_gnt", 32'(a_gnt), 32'h2);
        ack_a = 1'b1;
        #1;
        chk("t4_ack", 32'({a_m1_ack, a_m0_ack}), 32'h2);
        tick();
        ack_a = 1'b0;
        clear_masters();
        chk("t4_release", 32'(a_gnt), 32'h0);

        // m0 aborts, pending m1 gets the port
        do_reset();
        m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        chk("t5_gnt_m0", 32'(a_gnt), 32'h1);
        m1_adr = 32'h0000_0200; m1_cyc = 1'b1; m1_stb = 1'b1;
        m0_cyc = 1'b0;
        #1;
        chk("t5_abort_cyc", 32'({a_cyc, a_m0_ack, a_m1_ack}), 32'h0);
        tick();
        chk("t5_idle", 32'(a_gnt), 32'h0);
        tick();
        chk("t5_gnt_m1", 32'(a_gnt), 32'h2);
        chk("t5_adr_m1", a_adr, 32'h0000_0200);
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        clear_masters();

        // async reset mid-grant, then arbitration restarts with m0 first
        do_reset();
        m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        chk("t6_gnt_m0", 32'(a_gnt), 32'h1);
        rst_i = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(a_gnt), 32'h0);
        chk("t6_async_cyc", 32'(a_cyc), 32'h0);
        #2;
        rst_i = 1'b0;
        m1_adr = 32'h0000_0200; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        chk("t6_first_gnt", 32'(a_gnt), 32'h1);
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        clear_masters();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
